// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory bus of the boot loader.
// master: byte source / memory side; slave: prog_loader.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_run,
    input  load_done,
    input  load_err
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_run,
    output load_done,
    output load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: 16-bit word count header, then LE words to imem.
// Ports: clk, rst (async high), bus (rx in, mem/status out).
module prog_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);
  localparam int          WW      = $clog2(DEPTH + 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [WW-1:0] word_idx;
  logic [15:0]   count;

  logic        acc;
  logic [15:0] hdr;
  logic        last;

  assign acc  = bus.rx_valid & bus.rx_ready;
  assign hdr  = {bus.rx_data, count[7:0]};
  assign last = (32'(word_idx) + 32'd1)
                == 32'(count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HDR_LO;
      byte_idx      <= '0;
      word_idx      <= '0;
      count         <= '0;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= '0;
      bus.cpu_run   <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      unique case (state)
        HDR_LO: begin
          // ready rises on the first edge out of reset
          bus.rx_ready <= 1'b1;
          if (acc) begin
            count[7:0] <= bus.rx_data;
            state      <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (acc) begin
            count[15:8] <= bus.rx_data;
            if (hdr == 16'd0) begin
              state         <= DONE;
              bus.rx_ready  <= 1'b0;
              bus.cpu_run   <= 1'b1;
              bus.load_done <= 1'b1;
            end else if (32'(hdr) > DEPTH_U) begin
              state        <= ERR;
              bus.rx_ready <= 1'b0;
              bus.load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            bus.mem_wdata[{byte_idx, 3'b000} +: 8]
              <= bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state        <= WRITE;
              bus.mem_we   <= 1'b1;
              bus.rx_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          bus.mem_we   <= 1'b0;
          word_idx     <= word_idx + 1'b1;
          bus.mem_addr <= bus.mem_addr + 32'd4;
          if (last) begin
            state         <= DONE;
            bus.cpu_run   <= 1'b1;
            bus.load_done <= 1'b1;
          end else begin
            state        <= DATA;
            bus.rx_ready <= 1'b1;
          end
        end
        DONE: begin
          bus.rx_ready <= 1'b0;
        end
        ERR: begin
          bus.rx_ready <= 1'b0;
        end
        default: begin
          state        <= HDR_LO;
          bus.rx_ready <= 1'b0;
          bus.mem_we   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (DEPTH 1024 and 4),
// directed + random streams against a byte-count model.
module tb_prog_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s = 2'b11;
  logic [1:0] v = 2'b00;
  logic [7:0] dat [2];

  prog_loader_if ifa ();
  prog_loader_if ifb ();

  assign ifa.rx_valid = v[0];
  assign ifa.rx_data  = dat[0];
  assign ifb.rx_valid = v[1];
  assign ifb.rx_data  = dat[1];

  prog_loader #(.DEPTH(1024), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst_s[0]), .bus(ifa)
  );
  prog_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .rst(rst_s[1]), .bus(ifb)
  );

  logic        o_rdy  [2];
  logic        o_we   [2];
  logic [31:0] o_addr [2];
  logic [31:0] o_wd   [2];
  logic        o_run  [2];
  logic        o_done [2];
  logic        o_err  [2];

  assign o_rdy[0]  = ifa.rx_ready;
  assign o_we[0]   = ifa.mem_we;
  assign o_addr[0] = ifa.mem_addr;
  assign o_wd[0]   = ifa.mem_wdata;
  assign o_run[0]  = ifa.cpu_run;
  assign o_done[0] = ifa.load_done;
  assign o_err[0]  = ifa.load_err;
  assign o_rdy[1]  = ifb.rx_ready;
  assign o_we[1]   = ifb.mem_we;
  assign o_addr[1] = ifb.mem_addr;
  assign o_wd[1]   = ifb.mem_wdata;
  assign o_run[1]  = ifb.cpu_run;
  assign o_done[1] = ifb.load_done;
  assign o_err[1]  = ifb.load_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int depth(int d);
    return (d == 0) ? 1024 : 4;
  endfunction

  // model: bytes accepted so far, words completed, write pending
  int         n      [2];
  int         done_w [2];
  bit         wexp   [2];
  bit         fresh  [2];
  logic [7:0] mb     [2][4096];
  logic [63:0] log0[$];
  logic [63:0] log1[$];

  function automatic int mcount(int d);
    return int'({mb[d][1], mb[d][0]});
  endfunction

  function automatic logic [31:0] mword(int d, int k);
    return {mb[d][2+4*k+3], mb[d][2+4*k+2],
            mb[d][2+4*k+1], mb[d][2+4*k]};
  endfunction

  task automatic mon(int d);
    bit hv, er, dn, rd, acc;
    int c;
    if (rst_s[d]) begin
      n[d] = 0;
      done_w[d] = 0;
      wexp[d] = 1'b0;
      fresh[d] = 1'b1;
      chk("rst_ready", 32'(o_rdy[d]), 0);
      chk("rst_we",    32'(o_we[d]), 0);
      chk("rst_addr",  o_addr[d], 32'h0);
      chk("rst_wdata", o_wd[d], 32'h0);
      chk("rst_run",   32'(o_run[d]), 0);
      chk("rst_done",  32'(o_done[d]), 0);
      chk("rst_err",   32'(o_err[d]), 0);
      return;
    end
    hv = (n[d] >= 2);
    c  = hv ? mcount(d) : 0;
    er = hv && (c > depth(d));
    dn = hv && !er && (done_w[d] == c);
    rd = !fresh[d] && !wexp[d] && !dn && !er;
    chk("rx_ready",  32'(o_rdy[d]), 32'(rd));
    chk("mem_we",    32'(o_we[d]), 32'(wexp[d]));
    chk("cpu_run",   32'(o_run[d]), 32'(dn));
    chk("load_done", 32'(o_done[d]), 32'(dn));
    chk("load_err",  32'(o_err[d]), 32'(er));
    if (wexp[d]) begin
      chk("mem_addr", o_addr[d], 32'(4 * done_w[d]));
      chk("mem_wdata", o_wd[d], mword(d, done_w[d]));
      if (d == 0) log0.push_back({o_addr[d], o_wd[d]});
      else        log1.push_back({o_addr[d], o_wd[d]});
    end
    acc = v[d] && rd;
    if (wexp[d]) done_w[d]++;
    if (acc) begin
      mb[d][n[d]] = dat[d];
      n[d]++;
    end
    wexp[d]  = acc && (n[d] >= 6) && (((n[d] - 2) % 4) == 0);
    fresh[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic idle(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(int d, logic [7:0] b, int bound,
                           output bit ok);
    ok = 1'b0;
    v[d] = 1'b1;
    dat[d] = b;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (o_rdy[d]) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    v[d] = 1'b0;
  endtask

  // gap: idle cycles after each byte; hold_wr: no gap after a
  // word's 4th byte, so valid stays high across the write cycle
  task automatic send_seq(int d, input logic [7:0] q[$],
                          int gmin, int gmax, bit hold_wr);
    bit ok;
    int g;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(d, q[i], 20, ok);
      chk("accept", 32'(ok), 1);
      g = $urandom_range(gmax, gmin);
      if (hold_wr && i >= 2 && ((i - 2) % 4) == 3) g = 0;
      if (g > 0) idle(g);
    end
  endtask

  task automatic ignored(int d, int k);
    bit ok;
    for (int i = 0; i < k; i++) begin
      send_byte(d, 8'($urandom), 3, ok);
      chk("ignored", 32'(ok), 0);
    end
  endtask

  task automatic pulse_rst(int d);
    rst_s[d] = 1'b1;
    #1;
    chk("arst_ready", 32'(o_rdy[d]), 0);
    chk("arst_we",    32'(o_we[d]), 0);
    chk("arst_run",   32'(o_run[d]), 0);
    chk("arst_done",  32'(o_done[d]), 0);
    chk("arst_addr",  o_addr[d], 32'h0);
    if (d == 0) log0.delete();
    else        log1.delete();
    idle(2);
    rst_s[d] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    idle(3);
    rst_s = 2'b00;
    idle(2);

    // normal load
    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(0, q, 0, 0, 1'b0);
    idle(4);
    chk("norm_writes", log0.size(), 2);
    if (log0.size() == 2) begin
      chk("norm_a0", log0[0][63:32], 32'h0);
      chk("norm_d0", log0[0][31:0], 32'h12345678);
      chk("norm_a1", log0[1][63:32], 32'h4);
      chk("norm_d1", log0[1][31:0], 32'hDEADBEEF);
    end
    chk("norm_model_w1", mword(0, 1), 32'hDEADBEEF);
    chk("norm_run", 32'(o_run[0]), 1);
    chk("norm_done", 32'(o_done[0]), 1);
    ignored(0, 2);

    // empty image
    pulse_rst(0);
    q = '{8'h00, 8'h00};
    send_seq(0, q, 0, 0, 1'b0);
    idle(2);
    chk("empty_run", 32'(o_run[0]), 1);
    chk("empty_done", 32'(o_done[0]), 1);
    ignored(0, 2);
    chk("empty_writes", log0.size(), 0);

    // overflow: count 1025
    pulse_rst(0);
    q = '{8'h01, 8'h04};
    send_seq(0, q, 0, 0, 1'b0);
    idle(2);
    chk("ovf_err", 32'(o_err[0]), 1);
    chk("ovf_run", 32'(o_run[0]), 0);
    ignored(0, 8);
    chk("ovf_writes", log0.size(), 0);

    // gaps of 3, valid held through each write
    pulse_rst(0);
    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(0, q, 3, 3, 1'b1);
    idle(4);
    chk("gap_writes", log0.size(), 2);
    if (log0.size() == 2) begin
      chk("gap_d0", log0[0][31:0], 32'h12345678);
      chk("gap_d1", log0[1][31:0], 32'hDEADBEEF);
    end
    chk("gap_done", 32'(o_done[0]), 1);

    // reset after 5 data bytes, then a fresh image
    pulse_rst(0);
    q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_seq(0, q, 0, 0, 1'b0);
    pulse_rst(0);
    q = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_seq(0, q, 0, 0, 1'b0);
    idle(4);
    chk("rml_writes", log0.size(), 1);
    if (log0.size() == 1) begin
      chk("rml_a0", log0[0][63:32], 32'h0);
      chk("rml_d0", log0[0][31:0], 32'h11223344);
    end
    chk("rml_run", 32'(o_run[0]), 1);

    // exact capacity on DEPTH=4
    pulse_rst(1);
    q = '{8'h04, 8'h00};
    for (int k = 0; k < 4; k++) begin
      q.push_back(8'(k));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    send_seq(1, q, 0, 1, 1'b0);
    idle(4);
    chk("cap_writes", log1.size(), 4);
    if (log1.size() == 4) begin
      chk("cap_a3", log1[3][63:32], 32'hC);
      chk("cap_d3", log1[3][31:0], 32'h3);
    end
    chk("cap_done", 32'(o_done[1]), 1);
    chk("cap_err", 32'(o_err[1]), 0);

    // randomized images on both instances
    for (int it = 0; it < 24; it++) begin
      int d, c, cut;
      bit cut_it;
      d = it % 2;
      pulse_rst(d);
      if (d == 0)
        c = ($urandom_range(7, 0) == 0) ?
            $urandom_range(65535, 1025) : $urandom_range(10, 0);
      else
        c = $urandom_range(6, 0);
      q = '{8'(c), 8'(c >> 8)};
      if (c <= depth(d))
        for (int k = 0; k < 4 * c; k++)
          q.push_back(8'($urandom));
      cut_it = ($urandom_range(5, 0) == 0) && (q.size() > 3);
      if (cut_it) begin
        cut = $urandom_range(q.size() - 1, 2);
        while (q.size() > cut) void'(q.pop_back());
      end
      send_seq(d, q, 0, 3, $urandom_range(1, 0) == 1);
      if (!cut_it) begin
        idle(3);
        chk("rnd_done", 32'(o_done[d]), 32'(c <= depth(d)));
        chk("rnd_err", 32'(o_err[d]), 32'(c > depth(d)));
        chk("rnd_writes",
            (d == 0) ? log0.size() : log1.size(),
            (c <= depth(d)) ? c : 0);
        ignored(d, 1);
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the cpu core and its instruction memory.
- Receives a byte stream through a valid/ready handshake, for example from a UART receiver.
- Assembles the bytes into 32-bit little-endian words and writes them into instruction memory at sequential byte addresses.
- Holds the cpu in reset until the whole image has been written, then releases it.

Parameters:
- DEPTH, 1024, instruction memory capacity in 32-bit words; largest word count accepted.
- BASE_ADDR, 32'h0000_0000, byte address where word 0 is written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- rx_valid  input  1  rx_data holds a byte.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  instruction memory byte address.
- mem_wdata  output  32  assembled word.
- cpu_run  output  1  1 releases the cpu; drives the cpu's run/reset-release input.
- load_done  output  1  image fully written (sticky).
- load_err  output  1  header word count exceeded DEPTH (sticky).

Behaviour:
- Byte transfer: a byte is accepted on a rising clk edge only when rx_valid=1 and rx_ready=1. The sender holds rx_data stable while rx_valid=1 and rx_ready=0.
- Stream format:
  - Byte 0: count[7:0]. Byte 1: count[15:8].
  - Then 4*count bytes, one word after another, least significant byte first.
- Reset (rst=1, asynchronous) values:
  - State=HDR_LO, rx_ready=0 for the reset cycle, then 1 from the first edge after release.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_run=0, load_done=0, load_err=0.
  - Internal byte index=0, word index=0, count=0.
- Reset mid-load: everything returns to the reset values above. Words already written stay in memory. A new load restarts at the header.
- State machine:
  - HDR_LO: accept a byte into count[7:0], then go to HDR_HI.
  - HDR_HI: accept a byte into count[15:8], then:
    - full count=0 -> DONE;
    - full count>DEPTH -> ERR;
    - otherwise -> DATA.
  - DATA: accept a byte into word lane byte_idx (lane 0 = bits 7:0). When the lane-3 byte is accepted, go to WRITE.
  - WRITE: one cycle.
    - mem_we=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*word_idx.
    - rx_ready=0, so no byte is accepted this cycle.
    - Next cycle: word_idx increments. If word_idx+1==count -> DONE, else -> DATA.
  - DONE: rx_ready=0, load_done=1, cpu_run=1. Held until rst.
  - ERR: rx_ready=0, load_err=1, cpu_run=0. Held until rst. No memory write ever occurs for a rejected image.
- Latency:
  - mem_we rises on the clock edge that accepts the 4th byte of a word, i.e. it is high during the cycle after that acceptance.
  - cpu_run rises on the edge that ends the final WRITE cycle.
  - Maximum throughput is 4 bytes per 5 cycles.
- Output timing:
  - mem_addr is registered. It shows the address of the word being assembled and is valid whenever mem_we=1.
  - mem_we is low in every state except WRITE.
- Arithmetic:
  - count is 16 bits unsigned; the DEPTH comparison is unsigned.
  - word_idx is ceil(log2(DEPTH+1)) bits wide and never wraps, because count<=DEPTH.
  - Address arithmetic is 32 bits.
- Boundary cases:
  - Bytes sent after DONE or ERR are ignored, since rx_ready=0.
  - rx_valid toggling between bytes is legal; idle cycles do not change state.
  - count==DEPTH exactly is legal.

Test Plan:
- Normal load: stream 02 00 78 56 34 12 EF BE AD DE ->
  - write 0x12345678 @0x0, then 0xDEADBEEF @0x4;
  - exactly 2 mem_we pulses;
  - cpu_run=1 one cycle after the 2nd pulse; load_done=1.
- Empty image: stream 00 00 -> no mem_we; cpu_run=1 and load_done=1 after the 2nd byte; following bytes see rx_ready=0.
- Overflow: with DEPTH=1024, stream 01 04 (count=1025) -> load_err=1, cpu_run=0, no mem_we; 8 further bytes are not accepted.
- Back-pressure and gaps: same image as the normal load, with rx_valid deasserted 3 cycles between every byte and held high through each WRITE cycle -> identical writes; no byte is lost or duplicated.
- Reset mid-load: assert rst after 5 data bytes -> all outputs return to reset values immediately. Then stream 01 00 44 33 22 11 -> write 0x11223344 @BASE_ADDR; cpu_run=1.
- Exact capacity: DEPTH=4, count=4, words 0..3 ->
  - last write 0x00000003 @0xC;
  - load_done=1, load_err=0.
